// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// Handshake: start is taken only when the unit is idle or done and flush is low; busy stalls the
// issuer; valid is a one-cycle strobe and result holds until the next accepted start.
interface riscv_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] result;
  logic [1:0]        dbg_state;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, valid, result, dbg_state
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, valid, result, dbg_state
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M execute unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with the sign fix-up applied in a single cycle at the end.
module riscv_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               reset,
  riscv_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          f3;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [2*DATA_W-1:0] acc;
  logic                neg_res;
  logic                neg_rem;
  logic                busy_r;
  logic                valid_r;
  logic [DATA_W-1:0]   result_r;

  logic                accept;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag, fast_res, fix_res;
  logic                div_zero, div_ovf;
  logic [DATA_W:0]     mul_sum, rem_sh, diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot, rem;

  always_comb begin
    accept   = bus.start && !bus.flush && (state == IDLE || state == DONE);
    a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg    = a_signed && bus.op_a[DATA_W-1];
    b_neg    = b_signed && bus.op_b[DATA_W-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;
    div_zero = bus.funct3[2] && (bus.op_b == '0);
    // Only DIV/REM (funct3[0]==0) can overflow: most-negative / -1.
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (bus.op_b == '1);
    if (div_zero) fast_res = bus.funct3[1] ? bus.op_a : '1;
    else          fast_res = bus.funct3[1] ? '0 : bus.op_a;
  end

  // One iteration step: product accumulates in the upper half and shifts right;
  // the divide keeps the partial remainder in the upper half and the quotient in a_reg.
  always_comb begin
    mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (b_reg[0] ? {1'b0, a_reg} : '0);
    rem_sh  = {acc[2*DATA_W-1:DATA_W], a_reg[DATA_W-1]};
    diff    = rem_sh - {1'b0, b_reg};
  end

  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -a_reg : a_reg;
    rem  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    case (f3)
      3'b000:                 fix_res = prod[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      f3       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
          if (accept) begin
            f3      <= bus.funct3;
            a_reg   <= a_mag;
            b_reg   <= b_mag;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= CNT_W'(DATA_W);
            acc     <= '0;
            if (div_zero || div_ovf) begin
              result_r <= fast_res;
              valid_r  <= 1'b1;
              state    <= DONE;
            end else begin
              busy_r <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (f3[2]) begin
              if (!diff[DATA_W]) begin
                acc[2*DATA_W-1:DATA_W] <= diff[DATA_W-1:0];
                a_reg                  <= {a_reg[DATA_W-2:0], 1'b1};
              end else begin
                acc[2*DATA_W-1:DATA_W] <= rem_sh[DATA_W-1:0];
                a_reg                  <= {a_reg[DATA_W-2:0], 1'b0};
              end
            end else begin
              acc   <= {mul_sum, acc[DATA_W-1:1]};
              b_reg <= b_reg >> 1;
            end
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          busy_r <= 1'b0;
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            result_r <= fix_res;
            valid_r  <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.valid     = valid_r;
  assign bus.result    = result_r;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: a 32-bit and a 64-bit instance, scenario tasks and an
// expected-result queue checked when each valid strobe appears.
module tb_riscv_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_muldiv_unit_if #(.DATA_W(32)) bus32 ();
  riscv_muldiv_unit_if #(.DATA_W(64)) bus64 ();

  riscv_muldiv_unit #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  riscv_muldiv_unit #(.DATA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp64_q[$];

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; p = q; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; q = sa % sb; p = q; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.start = 1'b1; bus32.funct3 = f; bus32.op_a = a; bus32.op_b = b;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    // Operand churn after acceptance must not disturb the running operation.
    bus32.op_a = $urandom; bus32.op_b = $urandom; bus32.funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int limit, output int vcyc, output int vcount, output logic [31:0] res,
                           output int bfirst, output int blast, output int bcount);
    vcyc = 0; vcount = 0; res = '0; bfirst = 0; blast = 0; bcount = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus32.busy) begin if (bfirst == 0) bfirst = c; blast = c; bcount++; end
      if (bus32.valid) begin vcount++; if (vcyc == 0) begin vcyc = c; res = bus32.result; end end
      if (vcyc != 0 && c >= vcyc + 3) break;
    end
  endtask

  task automatic wait_done64(input int limit, output int vcyc, output int vcount, output logic [63:0] res);
    vcyc = 0; vcount = 0; res = '0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus64.valid) begin vcount++; if (vcyc == 0) begin vcyc = c; res = bus64.result; end end
      if (vcyc != 0 && c >= vcyc + 3) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus32.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus32.busy); end
    checks++; if (bus32.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus32.valid); end
    checks++; if (bus32.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus32.result); end
    checks++; if (bus32.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus32.dbg_state); end
    checks++; if (bus64.result !== 64'h0) begin failures++; $display("FAIL reset_result64 got=%h exp=0", bus64.result); end
  endtask

  task automatic test_mul_latency();
    int vcyc, vcount, bfirst, blast, bcount;
    logic [31:0] res, exp;
    exp_q.push_back(32'hFFFFFFEB);
    issue(3'b000, 32'd7, 32'hFFFFFFFD);
    wait_done(60, vcyc, vcount, res, bfirst, blast, bcount);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (res !== exp) begin failures++; $display("FAIL mul_result got=%h exp=%h", res, exp); end
    checks++; if (vcyc != 34) begin failures++; $display("FAIL mul_valid_cycle got=%0d exp=34", vcyc); end
    checks++; if (vcount != 1) begin failures++; $display("FAIL mul_valid_count got=%0d exp=1", vcount); end
    checks++; if (bfirst != 1 || blast != 33 || bcount != 33)
      begin failures++; $display("FAIL mul_busy_window got=%0d..%0d (%0d) exp=1..33 (33)", bfirst, blast, bcount); end
  endtask

  task automatic test_normal_ops();
    logic [2:0]  f [8] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111, 3'b000};
    logic [31:0] a [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100, 32'h12345678};
    logic [31:0] b [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3, 32'd7, 32'd7, 32'h10};
    logic [31:0] e [8] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2, 32'h23456780};
    int vcyc, vcount, bfirst, blast, bcount;
    logic [31:0] res, exp;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(e[i]);
      issue(f[i], a[i], b[i]);
      wait_done(60, vcyc, vcount, res, bfirst, blast, bcount);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      checks++; if (res !== exp) begin failures++; $display("FAIL op%0d_result f3=%0d got=%h exp=%h", i, f[i], res, exp); end
      checks++; if (vcyc != 34) begin failures++; $display("FAIL op%0d_valid_cycle got=%0d exp=34", i, vcyc); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int vcyc, vcount, bfirst, blast, bcount;
    logic [31:0] res, exp;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e[i]);
      issue(f[i], a[i], b[i]);
      wait_done(40, vcyc, vcount, res, bfirst, blast, bcount);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      checks++; if (res !== exp) begin failures++; $display("FAIL fast%0d_result got=%h exp=%h", i, res, exp); end
      checks++; if (vcyc != 1 || vcount != 1) begin failures++; $display("FAIL fast%0d_valid got=cyc%0d x%0d exp=cyc1 x1", i, vcyc, vcount); end
      checks++; if (bcount != 0) begin failures++; $display("FAIL fast%0d_busy got=%0d exp=0", i, bcount); end
    end
  endtask

  task automatic test_random();
    int vcyc, vcount, bfirst, blast, bcount, lat;
    logic [31:0] res, exp, a, b;
    logic [2:0] f;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      lat = (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 34;
      exp_q.push_back(model(f, a, b));
      issue(f, a, b);
      wait_done(60, vcyc, vcount, res, bfirst, blast, bcount);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      checks++; if (res !== exp || vcyc != lat)
        begin failures++; $display("FAIL rand%0d f3=%0d a=%h b=%h got=%h@%0d exp=%h@%0d", i, f, a, b, res, vcyc, exp, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int vcyc, vcount, bfirst, blast, bcount, first_cyc;
    logic [31:0] res, exp;
    exp_q.push_back(32'd14);
    issue(3'b101, 32'd100, 32'd7);
    first_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus32.valid) begin first_cyc = c; res = bus32.result; break; end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (first_cyc != 34 || res !== exp) begin failures++; $display("FAIL b2b_first got=%h@%0d exp=%h@34", res, first_cyc, exp); end
    exp_q.push_back(32'd2);
    bus32.start = 1'b1; bus32.funct3 = 3'b111; bus32.op_a = 32'd100; bus32.op_b = 32'd7;
    @(posedge clk); #1 bus32.start = 1'b0;
    wait_done(60, vcyc, vcount, res, bfirst, blast, bcount);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (res !== exp || vcyc != 34) begin failures++; $display("FAIL b2b_second got=%h@%0d exp=%h@34", res, vcyc, exp); end
  endtask

  task automatic test_flush();
    int vcyc, vcount, bfirst, blast, bcount, found;
    logic [31:0] res, exp;
    exp_q.push_back(32'd30);
    issue(3'b000, 32'd5, 32'd6);
    wait_done(60, vcyc, vcount, res, bfirst, blast, bcount);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (res !== exp) begin failures++; $display("FAIL flush_prior got=%h exp=%h", res, exp); end
    issue(3'b000, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    @(negedge clk) bus32.flush = 1'b1;
    @(posedge clk); #1 bus32.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus32.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus32.busy); end
    wait_done(40, vcyc, vcount, res, bfirst, blast, bcount);
    checks++; if (vcount != 0) begin failures++; $display("FAIL flush_no_valid got=%0d exp=0", vcount); end
    checks++; if (bus32.result !== 32'd30) begin failures++; $display("FAIL flush_hold got=%h exp=0000001e", bus32.result); end
    // start and flush together in IDLE: nothing is accepted
    @(negedge clk);
    bus32.start = 1'b1; bus32.flush = 1'b1; bus32.funct3 = 3'b100; bus32.op_a = 32'd9; bus32.op_b = 32'd0;
    @(posedge clk); #1 bus32.start = 1'b0; bus32.flush = 1'b0;
    wait_done(40, vcyc, vcount, res, bfirst, blast, bcount);
    checks++; if (vcount != 0 || bcount != 0) begin failures++; $display("FAIL flush_idle got=valid%0d busy%0d exp=0 0", vcount, bcount); end
    // flush in DONE: valid still seen, simultaneous start dropped
    exp_q.push_back(32'd14);
    issue(3'b101, 32'd100, 32'd7);
    found = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus32.valid) begin found = c; res = bus32.result; break; end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (found != 34 || res !== exp) begin failures++; $display("FAIL flush_done_valid got=%h@%0d exp=%h@34", res, found, exp); end
    bus32.start = 1'b1; bus32.flush = 1'b1; bus32.funct3 = 3'b101; bus32.op_a = 32'd5; bus32.op_b = 32'd0;
    @(posedge clk); #1 bus32.start = 1'b0; bus32.flush = 1'b0;
    wait_done(40, vcyc, vcount, res, bfirst, blast, bcount);
    checks++; if (vcount != 0 || bcount != 0) begin failures++; $display("FAIL flush_done_start got=valid%0d busy%0d exp=0 0", vcount, bcount); end
  endtask

  task automatic test_ignored_start();
    int vcyc, vcount;
    logic [31:0] res, exp;
    exp_q.push_back(32'd81);
    issue(3'b000, 32'd9, 32'd9);
    vcyc = 0; vcount = 0; res = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 5) begin bus32.start = 1'b1; bus32.funct3 = 3'b101; bus32.op_a = 32'd1; bus32.op_b = 32'd0; end
      if (c == 6) bus32.start = 1'b0;
      if (bus32.valid) begin vcount++; if (vcyc == 0) begin vcyc = c; res = bus32.result; end end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    checks++; if (vcount != 1) begin failures++; $display("FAIL ignored_start_count got=%0d exp=1", vcount); end
    checks++; if (res !== exp || vcyc != 34) begin failures++; $display("FAIL ignored_start_result got=%h@%0d exp=%h@34", res, vcyc, exp); end
  endtask

  task automatic test_reset_mid();
    int vcyc, vcount, bfirst, blast, bcount;
    logic [31:0] res;
    issue(3'b101, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus32.busy !== 1'b0 || bus32.valid !== 1'b0)
      begin failures++; $display("FAIL reset_mid_flags got=busy%b valid%b exp=0 0", bus32.busy, bus32.valid); end
    checks++; if (bus32.result !== 32'h0) begin failures++; $display("FAIL reset_mid_result got=%h exp=0", bus32.result); end
    checks++; if (bus32.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_mid_state got=%0d exp=0", bus32.dbg_state); end
    wait_done(40, vcyc, vcount, res, bfirst, blast, bcount);
    checks++; if (vcount != 0) begin failures++; $display("FAIL reset_mid_no_valid got=%0d exp=0", vcount); end
  endtask

  task automatic test_wide();
    logic [2:0]  f [3] = '{3'b011, 3'b101, 3'b100};
    logic [63:0] a [3] = '{64'hFFFFFFFFFFFFFFFF, 64'd1000000000000, 64'd77};
    logic [63:0] b [3] = '{64'hFFFFFFFFFFFFFFFF, 64'd7, 64'd0};
    logic [63:0] e [3] = '{64'hFFFFFFFFFFFFFFFE, 64'd142857142857, 64'hFFFFFFFFFFFFFFFF};
    int          l [3] = '{66, 66, 1};
    int vcyc, vcount;
    logic [63:0] res, exp;
    for (int i = 0; i < 3; i++) begin
      exp64_q.push_back(e[i]);
      @(negedge clk);
      bus64.start = 1'b1; bus64.funct3 = f[i]; bus64.op_a = a[i]; bus64.op_b = b[i];
      @(posedge clk); #1 bus64.start = 1'b0;
      wait_done64(100, vcyc, vcount, res);
      exp = (exp64_q.size() > 0) ? exp64_q.pop_front() : 64'hx;
      checks++; if (res !== exp || vcyc != l[i] || vcount != 1)
        begin failures++; $display("FAIL wide%0d got=%h@%0d x%0d exp=%h@%0d x1", i, res, vcyc, vcount, exp, l[i]); end
    end
  endtask

  initial begin
    bus32.start = 1'b0; bus32.flush = 1'b0; bus32.funct3 = '0; bus32.op_a = '0; bus32.op_b = '0;
    bus64.start = 1'b0; bus64.flush = 1'b0; bus64.funct3 = '0; bus64.op_a = '0; bus64.op_b = '0;
    test_reset();
    test_mul_latency();
    test_normal_ops();
    test_fast_path();
    test_random();
    test_back_to_back();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    test_wide();
    checks++; if (exp_q.size() != 0 || exp64_q.size() != 0)
      begin failures++; $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", exp_q.size(), exp64_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Iterative, parametrised RV32M/RV64M multiply/divide execute unit for the next-generation riscv core.
- Sits beside the ALU in the EX stage. Accepts one operation per start pulse and raises busy so the pipeline stalls.
- Returns a single-cycle valid pulse with the result.
- Implements all eight M-extension operations, including the architecturally defined divide-by-zero and signed-overflow results.

Parameters:
- DATA_W, 32, operand/result width (32 or 64); the iteration count equals DATA_W.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  DATA_W  rs1 value
- op_b  input  DATA_W  rs2 value
- flush  input  1  abort the in-flight operation (branch mispredict or exception)
- busy  output  1  high in CALC and FIX; the EX stage stalls on it
- valid  output  1  one-cycle result strobe
- result  output  DATA_W  result; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high, has priority over all inputs):
  - state goes to IDLE.
  - busy=0, valid=0, result=0.
  - Counter, accumulator and all operand registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- Accept condition: start=1 in IDLE or DONE, with flush=0.
- On the accept edge:
  - Latch funct3.
  - Latch the operand magnitudes. op_a is signed for MULH/MULHSU/DIV/REM; op_b is signed for MULH/DIV/REM.
  - Latch the result sign flags.
  - Load counter=DATA_W and clear the 2*DATA_W accumulator.
- Fast path on the accept edge (next state DONE, valid in cycle 1, where cycle 0 is the start cycle):
  - Divide by zero (op_b==0): DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a = most-negative value, op_b = all ones): DIV gives op_a; REM gives 0.
- Normal path (next state CALC):
  - Multiply: radix-2 shift-add, one bit per cycle, unsigned magnitudes.
  - Divide: restoring, one quotient bit per cycle, unsigned magnitudes.
  - CALC runs exactly DATA_W cycles, then goes to FIX.
- FIX (1 cycle):
  - Multiply: negate the 2*DATA_W product when the sign flags differ. MUL selects the low half; MULH/MULHSU/MULHU select the high half.
  - DIV: quotient is negated when the operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - Register the result; go to DONE.
- DONE (1 cycle): valid=1; busy=0.
  - Next state is IDLE, or CALC/DONE if a new start is accepted in this cycle (back-to-back).
- Normal-path latency: start in cycle 0; busy in cycles 1..DATA_W+1; valid in cycle DATA_W+2.
- While busy=1: start is ignored, and op_a/op_b/funct3 changes have no effect.
- flush:
  - In CALC or FIX: next state is IDLE; no valid is produced; result keeps its previous value.
  - In DONE: valid is still high that cycle (already committed); a start in the same cycle is not accepted.
  - In IDLE together with start: flush wins and nothing is accepted.
- Reset mid-operation behaves exactly as reset from any state.
- All arithmetic is two's complement, modulo 2^DATA_W at the output. No exceptions are raised.

Test Plan:
- DATA_W=32, MUL op_a=7, op_b=0xFFFFFFFD -> busy high cycles 1..33; valid only in cycle 34; result=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 -> result 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFF.
- Signed and unsigned divides:
  - DIV 0xFFFFFFEC/3 -> result 0xFFFFFFFA.
  - REM same operands -> result 0xFFFFFFFE.
  - DIVU 100/7 -> result 14.
  - REMU 100/7 -> result 2.
  - A back-to-back start issued in the DONE cycle is accepted.
- Fast path, each with valid in cycle 1 and busy never high:
  - DIV 5/0 -> result 0xFFFFFFFF.
  - REM 5/0 -> result 5.
  - DIV 0x80000000/0xFFFFFFFF -> result 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> result 0.
- Flush and ignored start:
  - Start MUL 3*4, assert flush in cycle 10 -> busy=0 in cycle 11; no valid ever; result holds its prior value.
  - A start pulsed during busy is ignored (no second valid).
- Reset and width:
  - Assert reset in cycle 20 of a DIVU -> next cycle busy=0, valid=0, result=0, state IDLE.
  - Rerun a subset with DATA_W=64: MULHU of all ones -> result 0xFFFFFFFFFFFFFFFE; valid in cycle 66.
